// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM write port of the loader, grouped for one-line hookup.
interface ram_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [13:0] ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;

  modport master (
    input  rx_data, rx_valid,
    output ram_addr, ram_in, ram_load
  );

  modport slave (
    output rx_data, rx_valid,
    input  ram_addr, ram_in, ram_load
  );
endinterface

// File: rtl/ram_loader.sv
// Frames a UART byte stream into 16-bit words, loads them into SPRAM from address 0,
// holds the CPU in reset meanwhile and verifies a trailing 16-bit checksum.
module ram_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned MAX_WORDS      = 16384
) (
  input  logic         clk,
  input  logic         reset,
  ram_loader_if.master bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         error
);
  localparam int unsigned TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAXW = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, SUM_HI, SUM_LO, CHECK
  } state_t;

  state_t        state, state_next;
  logic [15:0]   len, cnt, acc, sum_exp;
  logic [7:0]    hi_byte;
  logic [7:0]    hold_data;
  logic          hold_valid;
  logic [TW-1:0] tcnt;

  logic          byte_avail, counting, consume, abort;
  logic [7:0]    byte_in;
  logic [15:0]   len_word;

  // A byte parked during WRITE (or while a parked byte is consumed) is served first.
  always_comb begin
    byte_avail = hold_valid | bus.rx_valid;
    byte_in    = hold_valid ? hold_data : bus.rx_data;
    len_word   = {len[15:8], byte_in};
    counting   = !(state inside {IDLE, WRITE, CHECK});
    consume    = counting && byte_avail;
    abort      = 1'b0;
    state_next = state;
    case (state)
      IDLE:    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_next = LEN_HI;
      LEN_HI:  if (byte_avail) state_next = LEN_LO;
      LEN_LO: begin
        if (byte_avail) begin
          if ({1'b0, len_word} > MAXW) begin
            state_next = IDLE;
            abort      = 1'b1;
          end else if (len_word == '0) begin
            state_next = SUM_HI;
          end else begin
            state_next = DATA_HI;
          end
        end
      end
      DATA_HI: if (byte_avail) state_next = DATA_LO;
      DATA_LO: if (byte_avail) state_next = WRITE;
      WRITE:   state_next = (cnt + 16'd1 == len) ? SUM_HI : DATA_HI;
      SUM_HI:  if (byte_avail) state_next = SUM_LO;
      SUM_LO:  if (byte_avail) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (counting && !byte_avail && tcnt == TMAX) begin
      state_next = IDLE;
      abort      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.ram_addr <= '0;
      bus.ram_in   <= '0;
      bus.ram_load <= 1'b0;
      cpu_reset    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      len          <= '0;
      cnt          <= '0;
      acc          <= '0;
      sum_exp      <= '0;
      hi_byte      <= '0;
      hold_data    <= '0;
      hold_valid   <= 1'b0;
      tcnt         <= '0;
    end else begin
      state        <= state_next;
      bus.ram_load <= (state_next == WRITE);

      if (bus.rx_valid)  tcnt <= '0;
      else if (counting) tcnt <= tcnt + TW'(1);

      if (state_next == IDLE) begin
        hold_valid <= 1'b0;
      end else if (bus.rx_valid && (state == WRITE || (consume && hold_valid))) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.rx_data;
      end else if (consume && hold_valid) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (state_next == LEN_HI) begin
            done         <= 1'b0;
            error        <= 1'b0;
            bus.ram_addr <= '0;
            acc          <= '0;
            cnt          <= '0;
            cpu_reset    <= 1'b1;
          end
        end
        LEN_HI:  if (consume) len[15:8] <= byte_in;
        LEN_LO:  if (consume) len[7:0]  <= byte_in;
        DATA_HI: if (consume) hi_byte   <= byte_in;
        DATA_LO: begin
          if (consume) begin
            bus.ram_in <= {hi_byte, byte_in};
            acc        <= acc + {hi_byte, byte_in};
          end
        end
        WRITE: begin
          bus.ram_addr <= bus.ram_addr + 14'd1;
          cnt          <= cnt + 16'd1;
        end
        SUM_HI:  if (consume) sum_exp[15:8] <= byte_in;
        SUM_LO:  if (consume) sum_exp[7:0]  <= byte_in;
        CHECK: begin
          cpu_reset <= 1'b0;
          if (acc == sum_exp) done  <= 1'b1;
          else                error <= 1'b1;
        end
        default: ;
      endcase

      if (abort) begin
        error     <= 1'b1;
        cpu_reset <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: framing, write timing, checksum, length and timeout aborts.
module tb_ram_loader;
  logic clk = 1'b0;
  logic reset;
  logic cpu_reset, done, error;

  ram_loader_if bus ();

  ram_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [29:0] loads[$];

  always @(negedge clk) if (bus.ram_load === 1'b1) loads.push_back({bus.ram_addr, bus.ram_in});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; strobes one byte for exactly one cycle.
  task automatic put(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendb(input logic [7:0] b);
    put(b);
    gap(2);
  endtask

  task automatic chk_load(input string tag, input int unsigned idx,
                          input logic [13:0] addr, input logic [15:0] data);
    logic [29:0] got;
    got = (idx < loads.size()) ? loads[idx] : 30'h3fff_ffff;
    chk(tag, {2'b0, got}, {2'b0, addr, data});
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    gap(2);
    chk("rst_addr", 32'(bus.ram_addr), 0);
    chk("rst_in",   32'(bus.ram_in), 0);
    chk("rst_load", 32'(bus.ram_load), 0);
    chk("rst_cpu",  32'(cpu_reset), 0);
    chk("rst_flags", {30'b0, done, error}, 0);
    reset = 1'b0;
    gap(1);

    // Reset mid-frame, then a stray byte must be ignored
    sendb(8'hA5); sendb(8'h00); sendb(8'h02); sendb(8'h12);
    chk("mid_cpu_busy", 32'(cpu_reset), 1);
    reset = 1'b1;
    gap(1);
    reset = 1'b0;
    chk("mid_rst_cpu", 32'(cpu_reset), 0);
    chk("mid_rst_outs", {bus.ram_addr, bus.ram_in, bus.ram_load, done, error}, 0);
    loads.delete();
    sendb(8'h34);
    gap(2);
    chk("mid_no_load", loads.size(), 0);
    chk("mid_idle_cpu", 32'(cpu_reset), 0);

    // Two-word frame, spaced bytes
    loads.delete();
    put(8'hA5);
    chk("f2_cpu_after_sync", 32'(cpu_reset), 1);
    gap(2);
    sendb(8'h00); sendb(8'h02); sendb(8'h12); sendb(8'h34);
    sendb(8'hAB); sendb(8'hCD); sendb(8'hBE);
    put(8'h01);
    chk("f2_cpu_in_check", 32'(cpu_reset), 1);
    gap(1);
    chk("f2_cpu_released", 32'(cpu_reset), 0);
    chk("f2_done_err", {30'b0, done, error}, 2'b10);
    chk("f2_addr", 32'(bus.ram_addr), 2);
    chk("f2_nloads", loads.size(), 2);
    chk_load("f2_w0", 0, 14'd0, 16'h1234);
    chk_load("f2_w1", 1, 14'd1, 16'hABCD);

    // Bad checksum
    loads.delete();
    sendb(8'hA5); sendb(8'h00); sendb(8'h01); sendb(8'h00);
    sendb(8'h05); sendb(8'h00); sendb(8'h06);
    gap(2);
    chk("bad_sum_flags", {30'b0, done, error}, 2'b01);
    chk("bad_sum_nloads", loads.size(), 1);
    chk_load("bad_sum_w0", 0, 14'd0, 16'h0005);
    chk("bad_sum_cpu", 32'(cpu_reset), 0);

    // Length 16385 rejected right after LEN_LO
    loads.delete();
    sendb(8'hA5); sendb(8'h40);
    put(8'h01);
    chk("len_big_flags", {30'b0, done, error}, 2'b01);
    chk("len_big_cpu", 32'(cpu_reset), 0);
    gap(3);
    chk("len_big_nloads", loads.size(), 0);

    // Length 16384 is accepted; left to time out afterwards
    sendb(8'hA5); sendb(8'h40);
    put(8'h00);
    chk("len_max_ok", {29'b0, cpu_reset, done, error}, 3'b100);
    gap(20);
    chk("len_max_timeout", {29'b0, cpu_reset, done, error}, 3'b001);

    // Empty frame
    loads.delete();
    sendb(8'hA5); sendb(8'h00); sendb(8'h00); sendb(8'h00); sendb(8'h00);
    gap(1);
    chk("empty_flags", {30'b0, done, error}, 2'b10);
    chk("empty_nloads", loads.size(), 0);
    chk("empty_addr", 32'(bus.ram_addr), 0);

    // Back-to-back bytes, AB lands during the first WRITE
    loads.delete();
    put(8'hA5); put(8'h00); put(8'h02); put(8'h12);
    put(8'h34); put(8'hAB); put(8'hCD); put(8'hBE);
    gap(1);
    put(8'h01);
    gap(3);
    chk("b2b_flags", {29'b0, cpu_reset, done, error}, 3'b010);
    chk("b2b_addr", 32'(bus.ram_addr), 2);
    chk("b2b_nloads", loads.size(), 2);
    chk_load("b2b_w0", 0, 14'd0, 16'h1234);
    chk_load("b2b_w1", 1, 14'd1, 16'hABCD);

    // Timeout: error exactly 16 cycles after the last byte
    loads.delete();
    sendb(8'hA5); sendb(8'h00); sendb(8'h01);
    put(8'h12);
    gap(15);
    chk("to_before", {29'b0, cpu_reset, done, error}, 3'b100);
    gap(1);
    chk("to_at", {29'b0, cpu_reset, done, error}, 3'b001);
    chk("to_nloads", loads.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
